// File: rtl/coolgirl_scanline_irq_pkg.sv
// Shared definitions for the COOLGIRL MMC3-style scanline IRQ block.
package coolgirl_scanline_irq_pkg;

  localparam int CNT_W               = 8;
  localparam int A12_LOW_MIN_DEFAULT = 3;

  // Encoding is {A13, A0} within the $C000-$FFFF window.
  typedef enum logic [1:0] {
    IRQ_LATCH   = 2'b00,
    IRQ_RELOAD  = 2'b01,
    IRQ_DISABLE = 2'b10,
    IRQ_ENABLE  = 2'b11
  } irq_reg_e;

  function automatic irq_reg_e decode_reg(input logic a13, input logic a0);
    return irq_reg_e'({a13, a0});
  endfunction

endpackage

// File: rtl/coolgirl_a12_filter.sv
// PPU A12 synchronizer plus low-run filter; pulses clk_scan on a qualified rising edge.
module coolgirl_a12_filter
  import coolgirl_scanline_irq_pkg::*;
#(
  parameter int A12_LOW_MIN = A12_LOW_MIN_DEFAULT
) (
  input  logic m2,
  input  logic rst_n,
  input  logic enable,
  input  logic ppu_a12,
  output logic clk_scan
);

  localparam int LW = (A12_LOW_MIN > 0) ? $clog2(A12_LOW_MIN + 1) : 1;
  localparam logic [LW-1:0] LOW_MAX = LW'(A12_LOW_MIN);

  logic          sync1_q, sync2_q;
  logic [LW-1:0] low_cnt_q, low_cnt_d;

  always_comb begin
    low_cnt_d = low_cnt_q;
    if (sync2_q)                 low_cnt_d = '0;
    else if (low_cnt_q != LOW_MAX) low_cnt_d = low_cnt_q + 1'b1;
  end

  // NOTE: non-blocking assignments here so every flop samples pre-edge values.
  always_ff @(negedge m2 or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      low_cnt_q <= '0;
    end else if (!enable) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      low_cnt_q <= '0;
    end else begin
      sync1_q   <= ppu_a12;
      sync2_q   <= sync1_q;
      low_cnt_q <= low_cnt_d;
    end
  end

  // The low-run count is cleared one cycle after A12 goes high, so this is a single-cycle pulse.
  assign clk_scan = enable & sync2_q & (low_cnt_q == LOW_MAX);

endmodule

// File: rtl/coolgirl_scanline_irq.sv
// MMC3-style scanline counter and IRQ registers, clocked on the falling edge of CPU M2.
module coolgirl_scanline_irq
  import coolgirl_scanline_irq_pkg::*;
#(
  parameter int A12_LOW_MIN = A12_LOW_MIN_DEFAULT,
  parameter bit IRQ_REV_A   = 1'b0
) (
  input  logic        m2,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        romsel,
  input  logic        cpu_rw_in,
  input  logic [14:0] cpu_addr_in,
  input  logic [7:0]  cpu_data_in,
  input  logic        ppu_a12,
  output logic        irq
);

  logic [CNT_W-1:0] latch_q, latch_d, counter_q, counter_d, scan_next;
  logic             reload_q, reload_d, irq_en_q, irq_en_d, irq_pending_q, irq_pending_d;
  logic             clk_scan, wr_en, reload_path, set_ok, scan_take;
  irq_reg_e         wr_sel;
  logic             unused_addr;

  assign unused_addr = ^cpu_addr_in[12:1];

  coolgirl_a12_filter #(.A12_LOW_MIN(A12_LOW_MIN)) u_filter (
    .m2       (m2),
    .rst_n    (rst_n),
    .enable   (enable),
    .ppu_a12  (ppu_a12),
    .clk_scan (clk_scan)
  );

  always_comb begin
    wr_en       = !romsel && !cpu_rw_in && cpu_addr_in[14];
    wr_sel      = decode_reg(cpu_addr_in[13], cpu_addr_in[0]);
    reload_path = (counter_q == '0) || reload_q;
    scan_next   = reload_path ? latch_q : counter_q - CNT_W'(1);
    // Rev-A parts only raise IRQ from a reload when it follows real counting or a nonzero reload.
    set_ok      = !IRQ_REV_A || !reload_path || (counter_q != '0) || (reload_q && (latch_q != '0));
    scan_take   = clk_scan && !(wr_en && (wr_sel == IRQ_RELOAD));

    // NOTE: every _d defaults to its _q first so no path through this block infers a latch.
    latch_d       = latch_q;
    counter_d     = counter_q;
    reload_d      = reload_q;
    irq_en_d      = irq_en_q;
    irq_pending_d = irq_pending_q;

    if (scan_take) begin
      counter_d = scan_next;
      if (reload_path) reload_d = 1'b0;
      if ((scan_next == '0) && irq_en_q && set_ok) irq_pending_d = 1'b1;
    end

    // CPU writes are applied after the scan update so they take priority.
    if (wr_en) begin
      unique case (wr_sel)
        IRQ_LATCH:   latch_d = cpu_data_in;
        IRQ_RELOAD:  begin
          counter_d = '0;
          reload_d  = 1'b1;
        end
        IRQ_DISABLE: begin
          irq_en_d      = 1'b0;
          irq_pending_d = 1'b0;
        end
        IRQ_ENABLE:  irq_en_d = 1'b1;
      endcase
    end

    if (!enable) begin
      latch_d       = '0;
      counter_d     = '0;
      reload_d      = 1'b0;
      irq_en_d      = 1'b0;
      irq_pending_d = 1'b0;
    end
  end

  always_ff @(negedge m2 or negedge rst_n) begin
    if (!rst_n) begin
      latch_q       <= '0;
      counter_q     <= '0;
      reload_q      <= 1'b0;
      irq_en_q      <= 1'b0;
      irq_pending_q <= 1'b0;
    end else begin
      latch_q       <= latch_d;
      counter_q     <= counter_d;
      reload_q      <= reload_d;
      irq_en_q      <= irq_en_d;
      irq_pending_q <= irq_pending_d;
    end
  end

  assign irq = ~irq_pending_q;

endmodule

// File: tb/tb_coolgirl_scanline_irq.sv
// Directed bench for coolgirl_scanline_irq: default part and a rev-A part share one stimulus.
module tb_coolgirl_scanline_irq;

  logic        m2 = 1'b0;
  logic        rst_n, enable, romsel, cpu_rw_in, ppu_a12;
  logic [14:0] cpu_addr_in;
  logic [7:0]  cpu_data_in;
  logic        irq, irq_a;
  int          errors = 0;
  int          checks = 0;

  localparam logic [14:0] A_C000 = 15'h4000;
  localparam logic [14:0] A_C001 = 15'h4001;
  localparam logic [14:0] A_E000 = 15'h6000;
  localparam logic [14:0] A_E001 = 15'h6001;

  always #5 m2 = ~m2;

  coolgirl_scanline_irq dut (
    .m2(m2), .rst_n(rst_n), .enable(enable), .romsel(romsel), .cpu_rw_in(cpu_rw_in),
    .cpu_addr_in(cpu_addr_in), .cpu_data_in(cpu_data_in), .ppu_a12(ppu_a12), .irq(irq)
  );

  coolgirl_scanline_irq #(.IRQ_REV_A(1'b1)) dut_a (
    .m2(m2), .rst_n(rst_n), .enable(enable), .romsel(romsel), .cpu_rw_in(cpu_rw_in),
    .cpu_addr_in(cpu_addr_in), .cpu_data_in(cpu_data_in), .ppu_a12(ppu_a12), .irq(irq_a)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past one m2 fall; inputs are driven and outputs sampled 1 time unit later.
  task automatic tick();
    @(negedge m2);
    #1;
  endtask

  task automatic wr(input logic [14:0] a, input logic [7:0] d);
    cpu_addr_in = a;
    cpu_data_in = d;
    romsel      = 1'b0;
    cpu_rw_in   = 1'b0;
    tick();
    romsel      = 1'b1;
    cpu_rw_in   = 1'b1;
  endtask

  // Low for low_n falls, then rise; returns in the cycle where clk_scan is asserted.
  task automatic arm(input int low_n);
    ppu_a12 = 1'b0;
    repeat (low_n) tick();
    ppu_a12 = 1'b1;
    tick();
    tick();
  endtask

  task automatic pulse(input int low_n, input logic exp2, input logic exp3, input string tag);
    arm(low_n);
    check({tag, " irq@2"}, irq, exp2);
    tick();
    check({tag, " irq@3"}, irq, exp3);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; enable = 1'b1; romsel = 1'b1; cpu_rw_in = 1'b1;
    cpu_addr_in = '0; cpu_data_in = '0; ppu_a12 = 1'b1;
    #3;
    check("reset irq", irq, 1'b1);
    check("reset irq revA", irq_a, 1'b1);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check("reset counter", dut.counter_q, 8'h00);
    check("reset latch", dut.latch_q, 8'h00);

    // Scenario 1: latch 3, count down to IRQ on the fourth pulse.
    wr(A_C000, 8'h03); wr(A_C001, 8'h00); wr(A_E001, 8'h00);
    pulse(8, 1'b1, 1'b1, "s1 p1");
    check("s1 counter after p1", dut.counter_q, 8'h03);
    pulse(8, 1'b1, 1'b1, "s1 p2");
    pulse(8, 1'b1, 1'b1, "s1 p3");
    check("s1 counter after p3", dut.counter_q, 8'h01);
    pulse(8, 1'b1, 1'b0, "s1 p4");
    check("s1 irq revA", irq_a, 1'b0);

    // Scenario 2: $E000 acknowledges and disables.
    wr(A_E000, 8'h00);
    check("s2 irq after E000", irq, 1'b1);
    check("s2 irq_en", dut.irq_en_q, 1'b0);
    pulse(8, 1'b1, 1'b1, "s2 p1");
    pulse(8, 1'b1, 1'b1, "s2 p2");
    check("s2 counter", dut.counter_q, 8'h02);

    // Scenario 3: too-short low runs are filtered; exactly A12_LOW_MIN qualifies.
    wr(A_E001, 8'h00);
    pulse(2, 1'b1, 1'b1, "s3 short1");
    pulse(2, 1'b1, 1'b1, "s3 short2");
    pulse(2, 1'b1, 1'b1, "s3 short3");
    check("s3 counter unchanged", dut.counter_q, 8'h02);
    pulse(3, 1'b1, 1'b1, "s3 min run");
    check("s3 counter min run", dut.counter_q, 8'h01);

    // Scenario 5: $C001 coincident with clk_scan discards the scan.
    wr(A_C000, 8'h05); wr(A_C001, 8'h00);
    pulse(8, 1'b1, 1'b1, "s5 load");
    check("s5 counter loaded", dut.counter_q, 8'h05);
    arm(8);
    check("s5 scan aligned", dut.clk_scan, 1'b1);
    wr(A_C001, 8'h00);
    check("s5 counter cleared", dut.counter_q, 8'h00);
    check("s5 reload set", dut.reload_q, 1'b1);
    tick();
    pulse(8, 1'b1, 1'b1, "s5 next");
    check("s5 counter reloaded", dut.counter_q, 8'h05);
    check("s5 reload cleared", dut.reload_q, 1'b0);

    // $C000 coincident with a reload uses the old latch.
    wr(A_C001, 8'h00);
    arm(8);
    wr(A_C000, 8'h07);
    check("c000 old latch used", dut.counter_q, 8'h05);
    check("c000 latch updated", dut.latch_q, 8'h07);
    tick();

    // Scenario 4: latch 0 differs between default and rev-A parts.
    wr(A_E000, 8'h00); wr(A_C000, 8'h00); wr(A_C001, 8'h00); wr(A_E001, 8'h00);
    pulse(8, 1'b1, 1'b0, "s4");
    check("s4 irq revA", irq_a, 1'b1);
    wr(A_E001, 8'h00);
    check("E001 keeps pending", irq, 1'b0);

    // $E000 coincident with a setting clk_scan: the write wins.
    arm(8);
    wr(A_E000, 8'h00);
    check("E000 beats scan", irq, 1'b1);
    tick();
    check("E000 irq_en", dut.irq_en_q, 1'b0);

    // enable=0 clears state synchronously.
    wr(A_E001, 8'h00);
    pulse(8, 1'b1, 1'b0, "en set");
    wr(A_C000, 8'h09);
    enable = 1'b0;
    tick();
    check("disable irq", irq, 1'b1);
    check("disable latch", dut.latch_q, 8'h00);
    enable = 1'b1;
    tick();

    // Scenario 6: asynchronous reset mid-count with IRQ pending.
    wr(A_C000, 8'h02); wr(A_E001, 8'h00);
    pulse(8, 1'b1, 1'b1, "s6 p1");
    pulse(8, 1'b1, 1'b1, "s6 p2");
    pulse(8, 1'b1, 1'b0, "s6 p3");
    pulse(8, 1'b0, 1'b0, "s6 p4");
    check("s6 counter mid", dut.counter_q, 8'h02);
    rst_n = 1'b0;
    #1;
    check("s6 irq async", irq, 1'b1);
    check("s6 counter", dut.counter_q, 8'h00);
    check("s6 latch", dut.latch_q, 8'h00);
    check("s6 reload", dut.reload_q, 1'b0);
    check("s6 irq_en", dut.irq_en_q, 1'b0);
    check("s6 pending", dut.irq_pending_q, 1'b0);
    ppu_a12 = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    ppu_a12 = 1'b1;
    tick(); tick(); tick();
    check("s6 counter after release", dut.counter_q, 8'h00);
    check("s6 irq after release", irq, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/coolgirl_scanline_irq.md
COOLGIRL_SCANLINE_IRQ -- requirements
Module: coolgirl_scanline_irq

Interface
REQ-001 Parameter A12_LOW_MIN, default 3: minimum consecutive low samples of PPU A12 before a rising edge qualifies as a scanline clock.
REQ-002 Parameter IRQ_REV_A, default 0: 1 selects MMC3 rev-A reload semantics (see REQ-014).
REQ-003 m2  input  1  CPU M2; the only clock. All flops update on the falling edge of m2, where CPU write data is valid.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 enable  input  1  mapper selects MMC3-style IRQ; when 0 the block holds its reset state.
REQ-006 romsel  input  1  CPU /ROMSEL, active-low.
REQ-007 cpu_rw_in  input  1  CPU R/W; 0 = write.
REQ-008 cpu_addr_in  input  15  CPU A14..A0.
REQ-009 cpu_data_in  input  8  CPU data bus, sampled on writes.
REQ-010 ppu_a12  input  1  raw PPU A12, asynchronous to m2.
REQ-011 irq  output  1  active-low IRQ to the top level; low while irq_pending=1.

Function
REQ-012 Register decode: a write is romsel=0, cpu_rw_in=0, sampled at the m2 fall. Selection uses A14, A13 and A0:
- $C000 (A14=1, A13=0, A0=0): latch <= data.
- $C001 (A14=1, A13=0, A0=1): counter <= 0, reload <= 1.
- $E000 (A14=1, A13=1, A0=0): irq_en <= 0, irq_pending <= 0.
- $E001 (A14=1, A13=1, A0=1): irq_en <= 1.
REQ-013 A12 path: two-flop synchronizer, then low-run counter saturating at A12_LOW_MIN. A rising edge of the synchronized A12 raises the one-cycle pulse clk_scan only if the low-run counter equals A12_LOW_MIN. Any high sample clears the low-run counter.
REQ-014 On clk_scan:
- If counter==0 or reload==1: next = latch, and reload <= 0. Otherwise next = counter-1.
- counter <= next.
- If next==0 and irq_en==1: irq_pending <= 1.
- With IRQ_REV_A=1, a reload path only sets pending when the old counter was nonzero or reload was set with latch!=0.
REQ-015 Counter arithmetic is 8-bit unsigned. A decrement from 1 gives 0. No wrap below 0 is possible, because 0 always reloads.
REQ-016 Latency: irq falls on the m2 fall after the clk_scan cycle, i.e. 3 m2 cycles after the A12 rise (2 synchronizer + 1 counter).
REQ-017 Simultaneous events in one cycle:
- $E000 write with a setting clk_scan: the write wins; pending=0.
- $C001 write with clk_scan: the write wins; counter=0, reload=1, and the scan event is discarded.
- $C000 write with a reload: the old latch is used.
REQ-018 latch=0 with IRQ_REV_A=0: every qualified edge reloads 0 and sets pending if irq_en=1.
REQ-019 irq_pending stays set until a $E000 write or reset. Writing $E001 does not clear it.
REQ-020 enable=0 forces synchronous clear of counter, latch, reload, irq_en, irq_pending and the filter; irq=1.

Reset
REQ-021 On rst_n=0, asynchronously:
- latch=0, counter=0, reload=0, irq_en=0, irq_pending=0.
- Synchronizer flops=1, low-run counter=0.
- irq=1.
REQ-022 A12 edges that occur while rst_n=0, or in the first two cycles after release, do not clock the counter.
REQ-023 Reset asserted mid-count discards all state. No partial write survives.

Structure
REQ-024 The shared package holds:
- register select codes (IRQ_LATCH, IRQ_RELOAD, IRQ_DISABLE, IRQ_ENABLE);
- default A12_LOW_MIN;
- the counter width constant (8).
REQ-025 The synchronizer and low-run filter are one sub-module, coolgirl_a12_filter (ports m2, rst_n, ppu_a12, clk_scan). The counter and registers stay in the parent.

Verification
REQ-026 Scenario 1: latch=$03, $C001, $E001, then 4 qualified A12 pulses (low 8 m2 each). Required: irq stays 1 through pulses 1..3; irq goes 0 exactly 3 m2 after the 4th rise.
REQ-027 Scenario 2: pending set, write $E000. Required: irq=1 on the next m2 fall, irq_en=0, and further pulses leave irq=1.
REQ-028 Scenario 3: A12 low only 2 m2 between rises (A12_LOW_MIN=3). Required: counter unchanged, no irq.
REQ-029 Scenario 4: latch=0, irq_en=1, one qualified pulse. Required: with IRQ_REV_A=0, irq=0; with IRQ_REV_A=1, irq stays 1.
REQ-030 Scenario 5: $C001 write coincident with clk_scan while counter=$05. Required: counter=0, reload=1; the next pulse loads latch.
REQ-031 Scenario 6: rst_n pulsed low mid-count with pending=1. Required: irq=1 immediately, with no m2 edge needed; all registers are zero after release.
